musa_pc_unit: RTL and testbench
===============================

Name: musa_pc_unit

Overview:
- Program-counter stage that consumes the control unit's sequencing outputs: write_pc, branch[2:0], push, pop, add_pc and brfl_control.
- Computes and registers the next PC, and owns the hardware call/return stack.
- Feeds pc to the instruction memory/fetch path; the fetched opcode returns to the control unit.
- One PC update per instruction, on the cycle write_pc is asserted.

Parameters:
- ADDR_W, 32, PC / address width.
- STACK_DEPTH, 8, number of return-address entries (power of two, >=2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- write_pc  in  1  one-cycle strobe from control unit; commit next PC.
- branch  in  3  000 seq, 001 jr, 010 call, 011 halt, 100 jpc; other codes behave as seq.
- push  in  1  call: save return address.
- pop  in  1  ret: restore return address.
- add_pc  in  1  qualifies pop as a return; the PC is loaded from stack top.
- brfl_control  in  1  conditional branch-on-flag instruction.
- flag_true  in  1  ALU flag result for brfl.
- reg_target  in  ADDR_W  register operand (jr target, absolute).
- imm  in  16  instruction immediate; sign-extended to ADDR_W.
- jump_target  in  26  call absolute target; zero-extended to ADDR_W.
- pc  out  ADDR_W  current PC.
- halted  out  1  sticky halt indication.
- stack_depth  out  $clog2(STACK_DEPTH)+1  number of valid stack entries.
- stack_err  out  1  sticky overflow/underflow/conflict flag.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, halted=0, stack_depth=0, stack_err=0. Stack contents are don't-care.
- No state changes unless write_pc=1 and halted=0. When halted=1, write_pc is ignored and pc holds.
- On a write_pc cycle, evaluate in priority order; the first match wins:
  1. push=1 and pop=1: conflict. stack_err<=1, pc<=pc+1, stack unchanged.
  2. branch=011 (halt): halted<=1, pc unchanged.
  3. pop=1 and add_pc=1 (ret):
     - depth>0: pc<=top, depth-1.
     - depth==0: stack_err<=1, pc<=pc+1.
  4. branch=010 (call): pc<=zext(jump_target).
     - Not full: push pc+1, depth+1.
     - Full: stack_err<=1, no push. The jump is still taken.
  5. branch=001 (jr): pc<=reg_target.
  6. branch=100 (jpc): pc<=pc+1+sext(imm).
  7. brfl_control=1 and flag_true=1: pc<=pc+1+sext(imm).
  8. Otherwise: pc<=pc+1.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_W; pc wraps from max to 0 without error.
- Latency: the new pc is visible the cycle after the write_pc edge. Update rate is one per write_pc pulse.
- A pop without add_pc, or a push without call, is ignored.
- Stack is LIFO. The top entry is readable combinationally for a same-cycle ret.
- Reset mid-instruction wins immediately; no partial update survives.

Optional Feature:
- Macro: MUSA_RAS_WRAP_EN.
- Defined: the stack is circular. A call when full overwrites the oldest entry, depth saturates at STACK_DEPTH, and stack_err is not set for overflow. Underflow still sets stack_err.
- Undefined: overflow behaviour is as in rule 4 (push dropped, stack_err set).

Decomposition:
- Package musa_pc_pkg holds:
  - branch encodings: BR_SEQ, BR_JR, BR_CALL, BR_HALT, BR_JPC.
  - default ADDR_W.
  - a sign-extend function for the 16-bit immediate.
- Sub-module musa_return_stack (params ADDR_W, STACK_DEPTH):
  - Ports: push, pop, wdata, top, depth, full, empty, overflow/underflow pulses.
  - Contains the wrap logic under MUSA_RAS_WRAP_EN.
- musa_pc_unit holds only next-PC selection, halted and stack_err.

Test Plan:
- Reset, then 3 write_pc pulses with branch=000 -> pc 0,1,2,3; halted=0; stack_depth=0.
- pc=5, call with jump_target=0x40 -> pc=0x40, depth=1. Then ret (pop=1, add_pc=1) -> pc=6, depth=0.
- pc=10: jpc with imm=0xFFFC -> pc=7. brfl with flag_true=0 -> pc=8. brfl with flag_true=1, imm=4 -> pc=13.
- Ret at depth 0 -> stack_err=1, pc+1. Then STACK_DEPTH+1 calls:
  - without macro: depth=8, last return address dropped;
  - with MUSA_RAS_WRAP_EN: depth=8, 8 rets return the newest 8 addresses in LIFO order.
- Halt at pc=20 -> halted=1. Further write_pc pulses with branch=000 -> pc stays 20. Assert rst_n=0 mid-cycle -> pc=0, halted=0 immediately.
- Push and pop asserted together at pc=3 -> pc=4, stack_err=1, depth unchanged. jr with reg_target=0xFFFFFFFF, then seq -> pc wraps to 0.

Source files
------------

// File: rtl/musa_pc_pkg.sv
// Shared definitions for the MUSA program-counter stage: branch codes,
// default address width and the immediate sign-extension helper.
package musa_pc_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int MAX_ADDR_W = 64;

  typedef enum logic [2:0] {
    BR_SEQ  = 3'b000,
    BR_JR   = 3'b001,
    BR_CALL = 3'b010,
    BR_HALT = 3'b011,
    BR_JPC  = 3'b100
  } branch_e;

  // Extends to the widest supported PC; callers size-cast down to ADDR_W.
  function automatic logic [MAX_ADDR_W-1:0] sext_imm(input logic [15:0] imm);
    return {{(MAX_ADDR_W-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/musa_return_stack.sv
// LIFO return-address stack with combinational top-of-stack read.
// Define MUSA_RAS_WRAP_EN to make it circular (overflow overwrites oldest).
module musa_return_stack
  import musa_pc_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int STACK_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [ADDR_W-1:0]              wdata_i,
  output logic [ADDR_W-1:0]              top_o,
  output logic [$clog2(STACK_DEPTH):0]   depth_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic                           overflow_o,
  output logic                           underflow_o
);

  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [PTR_W:0]    depth_q, depth_d;
  logic              wr_en;

  assign full_o  = (depth_q == (PTR_W+1)'(STACK_DEPTH));
  assign empty_o = (depth_q == '0);
  assign depth_o = depth_q;
  // sp_q points at the next free slot; power-of-two depth makes it wrap for free.
  assign top_o   = mem_q[sp_q - PTR_W'(1)];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    sp_d        = sp_q;
    depth_d     = depth_q;
    wr_en       = 1'b0;
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    if (push_i) begin
      if (!full_o) begin
        wr_en   = 1'b1;
        sp_d    = sp_q + PTR_W'(1);
        depth_d = depth_q + (PTR_W+1)'(1);
      end else begin
`ifdef MUSA_RAS_WRAP_EN
        wr_en = 1'b1;
        sp_d  = sp_q + PTR_W'(1);
`else
        overflow_o = 1'b1;
`endif
      end
    end else if (pop_i) begin
      if (!empty_o) begin
        sp_d    = sp_q - PTR_W'(1);
        depth_d = depth_q - (PTR_W+1)'(1);
      end else begin
        underflow_o = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q    <= '0;
      depth_q <= '0;
    end else begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
    end
  end

  // NOTE: storage is deliberately not reset; depth_q alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[sp_q] <= wdata_i;
  end

endmodule

// File: rtl/musa_pc_unit.sv
// Program-counter stage: next-PC selection, sticky halt and stack error.
// Optional circular return stack via MUSA_RAS_WRAP_EN (see musa_return_stack).
module musa_pc_unit
  import musa_pc_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         write_pc_i,
  input  logic [2:0]                   branch_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         add_pc_i,
  input  logic                         brfl_control_i,
  input  logic                         flag_true_i,
  input  logic [ADDR_W-1:0]            reg_target_i,
  input  logic [15:0]                  imm_i,
  input  logic [25:0]                  jump_target_i,
  output logic [ADDR_W-1:0]            pc_o,
  output logic                         halted_o,
  output logic [$clog2(STACK_DEPTH):0] stack_depth_o,
  output logic                         stack_err_o
);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, pc_rel, rs_top;
  logic              halted_q, halted_d, err_q, err_d;
  logic              rs_push, rs_pop, conflict;
  logic              rs_full, rs_empty, rs_overflow, rs_underflow;

  assign pc_inc = pc_q + ADDR_W'(1);
  assign pc_rel = pc_inc + ADDR_W'(sext_imm(imm_i));

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    rs_push  = 1'b0;
    rs_pop   = 1'b0;
    conflict = 1'b0;
    if (write_pc_i && !halted_q) begin
      if (push_i && pop_i) begin
        conflict = 1'b1;
        pc_d     = pc_inc;
      end else if (branch_i == BR_HALT) begin
        halted_d = 1'b1;
      end else if (pop_i && add_pc_i) begin
        rs_pop = 1'b1;
        pc_d   = rs_empty ? pc_inc : rs_top;
      end else if (branch_i == BR_CALL) begin
        rs_push = 1'b1;
        pc_d    = ADDR_W'(jump_target_i);
      end else if (branch_i == BR_JR) begin
        pc_d = reg_target_i;
      end else if (branch_i == BR_JPC) begin
        pc_d = pc_rel;
      end else if (brfl_control_i && flag_true_i) begin
        pc_d = pc_rel;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  assign err_d = err_q | conflict | rs_overflow | rs_underflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  musa_return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (rs_push),
    .pop_i       (rs_pop),
    .wdata_i     (pc_inc),
    .top_o       (rs_top),
    .depth_o     (stack_depth_o),
    .full_o      (rs_full),
    .empty_o     (rs_empty),
    .overflow_o  (rs_overflow),
    .underflow_o (rs_underflow)
  );

  // A dropped push can only ever come from a full stack.
  assert property (@(posedge clk) disable iff (!rst_n) rs_overflow |-> rs_full);

  assign pc_o        = pc_q;
  assign halted_o    = halted_q;
  assign stack_err_o = err_q;

endmodule

// File: tb/tb_musa_pc_unit.sv
// Self-checking bench for musa_pc_unit: directed scenarios plus random
// instruction streams against a queue-based reference model.
module tb_musa_pc_unit;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_pc = 1'b0;
  logic [2:0]  branch = '0;
  logic        push = 1'b0, pop = 1'b0, add_pc = 1'b0, brfl = 1'b0, flag = 1'b0;
  logic [31:0] reg_target = '0;
  logic [15:0] imm = '0;
  logic [25:0] jump_target = '0;
  logic [31:0] pc;
  logic        halted, stack_err;
  logic [3:0]  stack_depth;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_halted, m_err;
  logic [31:0] m_stack[$];

  always #5 clk = ~clk;

  musa_pc_unit #(.ADDR_W(32), .STACK_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .write_pc_i(write_pc), .branch_i(branch),
    .push_i(push), .pop_i(pop), .add_pc_i(add_pc), .brfl_control_i(brfl),
    .flag_true_i(flag), .reg_target_i(reg_target), .imm_i(imm),
    .jump_target_i(jump_target), .pc_o(pc), .halted_o(halted),
    .stack_depth_o(stack_depth), .stack_err_o(stack_err)
  );

  task automatic model_reset();
    m_pc = 32'h0; m_halted = 1'b0; m_err = 1'b0;
    m_stack.delete();
  endtask

  task automatic model_step(input logic [2:0] br, input logic psh, pp, apc, bfl, flg,
                            input logic [31:0] rt, input logic [15:0] im, input logic [25:0] jt);
    logic [31:0] nxt, rel;
    if (m_halted) return;
    nxt = m_pc + 32'd1;
    rel = nxt + {{16{im[15]}}, im};
    if (psh && pp) begin
      m_err = 1'b1; m_pc = nxt;
    end else if (br == 3'd3) begin
      m_halted = 1'b1;
    end else if (pp && apc) begin
      if (m_stack.size() == 0) begin m_err = 1'b1; m_pc = nxt; end
      else m_pc = m_stack.pop_back();
    end else if (br == 3'd2) begin
      if (m_stack.size() < DEPTH) m_stack.push_back(nxt);
      else begin
`ifdef MUSA_RAS_WRAP_EN
        void'(m_stack.pop_front());
        m_stack.push_back(nxt);
`else
        m_err = 1'b1;
`endif
      end
      m_pc = {6'b0, jt};
    end else if (br == 3'd1) m_pc = rt;
    else if (br == 3'd4) m_pc = rel;
    else if (bfl && flg) m_pc = rel;
    else m_pc = nxt;
  endtask

  task automatic issue(input logic [2:0] br, input logic psh, pp, apc, bfl, flg,
                       input logic [31:0] rt, input logic [15:0] im, input logic [25:0] jt);
    @(negedge clk);
    branch = br; push = psh; pop = pp; add_pc = apc; brfl = bfl; flag = flg;
    reg_target = rt; imm = im; jump_target = jt; write_pc = 1'b1;
    @(negedge clk);
    write_pc = 1'b0;
    model_step(br, psh, pp, apc, bfl, flg, rt, im, jt);
  endtask

  task automatic do_seq();                     issue(3'd0, 0, 0, 0, 0, 0, '0, '0, '0); endtask
  task automatic do_jr(input logic [31:0] t);  issue(3'd1, 0, 0, 0, 0, 0, t, '0, '0);  endtask
  task automatic do_call(input logic [25:0] t); issue(3'd2, 1, 0, 0, 0, 0, '0, '0, t); endtask
  task automatic do_ret();                     issue(3'd0, 0, 1, 1, 0, 0, '0, '0, '0); endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; write_pc = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", pc); else passed++;
    checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else passed++;
    checks++; if (stack_depth !== 4'd0) $display("FAIL reset_depth: got %0d want 0", stack_depth); else passed++;
    checks++; if (stack_err !== 1'b0) $display("FAIL reset_err: got %b want 0", stack_err); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_seq();
    for (int i = 1; i <= 3; i++) begin
      do_seq();
      checks++; if (pc !== 32'(i)) $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, 32'(i)); else passed++;
    end
    checks++; if (halted !== 1'b0 || stack_depth !== 4'd0)
      $display("FAIL seq_status: halted %b depth %0d want 0/0", halted, stack_depth); else passed++;
  endtask

  task automatic test_call_ret();
    do_jr(32'd5);
    do_call(26'h40);
    checks++; if (pc !== 32'h40 || stack_depth !== 4'd1)
      $display("FAIL call: pc %h depth %0d want 40/1", pc, stack_depth); else passed++;
    do_ret();
    checks++; if (pc !== 32'd6 || stack_depth !== 4'd0)
      $display("FAIL ret: pc %h depth %0d want 6/0", pc, stack_depth); else passed++;
  endtask

  task automatic test_branches();
    do_jr(32'd10);
    issue(3'd4, 0, 0, 0, 0, 0, '0, 16'hFFFC, '0);
    checks++; if (pc !== 32'd7) $display("FAIL jpc_neg: got %h want 7", pc); else passed++;
    issue(3'd0, 0, 0, 0, 1, 0, '0, 16'd4, '0);
    checks++; if (pc !== 32'd8) $display("FAIL brfl_nt: got %h want 8", pc); else passed++;
    issue(3'd0, 0, 0, 0, 1, 1, '0, 16'd4, '0);
    checks++; if (pc !== 32'd13) $display("FAIL brfl_t: got %h want 13", pc); else passed++;
  endtask

  task automatic test_stack_limits();
    do_reset();
    do_seq();
    do_ret();
    checks++; if (stack_err !== 1'b1 || pc !== 32'd2)
      $display("FAIL underflow: err %b pc %h want 1/2", stack_err, pc); else passed++;
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      do_call(26'(32'h100 + 32'(i) * 32'h10));
      checks++; if (pc !== m_pc || stack_err !== m_err)
        $display("FAIL call_fill[%0d]: pc %h err %b want %h/%b", i, pc, stack_err, m_pc, m_err); else passed++;
    end
    checks++; if (stack_depth !== 4'd8) $display("FAIL full_depth: got %0d want 8", stack_depth); else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      do_ret();
      checks++; if (pc !== m_pc || stack_depth !== 4'(m_stack.size()))
        $display("FAIL lifo_ret[%0d]: pc %h depth %0d want %h/%0d", i, pc, stack_depth, m_pc, m_stack.size()); else passed++;
    end
    do_ret();
    checks++; if (stack_err !== 1'b1) $display("FAIL drain_underflow: got %b want 1", stack_err); else passed++;
  endtask

  task automatic test_halt_reset();
    do_reset();
    do_jr(32'd20);
    issue(3'd3, 0, 0, 0, 0, 0, '0, '0, '0);
    checks++; if (halted !== 1'b1 || pc !== 32'd20)
      $display("FAIL halt: halted %b pc %h want 1/20", halted, pc); else passed++;
    repeat (3) do_seq();
    checks++; if (pc !== 32'd20) $display("FAIL halt_hold: got %h want 20", pc); else passed++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0 || halted !== 1'b0)
      $display("FAIL async_reset: pc %h halted %b want 0/0", pc, halted); else passed++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_conflict_wrap();
    do_call(26'd2);
    do_seq();
    issue(3'd0, 1, 1, 1, 0, 0, '0, '0, '0);
    checks++; if (pc !== 32'd4 || stack_err !== 1'b1 || stack_depth !== 4'd1)
      $display("FAIL conflict: pc %h err %b depth %0d want 4/1/1", pc, stack_err, stack_depth); else passed++;
    do_jr(32'hFFFF_FFFF);
    do_seq();
    checks++; if (pc !== 32'h0) $display("FAIL pc_wrap: got %h want 0", pc); else passed++;
  endtask

  task automatic test_random();
    logic [2:0] br;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (m_halted && $urandom_range(0, 2) == 0) do_reset();
      br = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
      if (br == 3'd3 && $urandom_range(0, 1) == 0) br = 3'd0;
      issue(br, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
            1'($urandom), 1'($urandom), $urandom, 16'($urandom), 26'($urandom));
      checks++;
      if (pc !== m_pc || halted !== m_halted || stack_err !== m_err || stack_depth !== 4'(m_stack.size()))
        $display("FAIL random[%0d]: pc %h h %b e %b d %0d want %h/%b/%b/%0d", n, pc, halted, stack_err,
                 stack_depth, m_pc, m_halted, m_err, m_stack.size());
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_call_ret();
    test_branches();
    test_stack_limits();
    test_halt_reset();
    test_conflict_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
